// File: rtl/pll_rst_seq.sv
// PLL reset sequencer and lock supervisor.
// Runs on the reference clock, holds the PLL in reset, waits for a stable
// lock and only then releases the system reset.

module pll_rst_seq #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       soft_rst_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       pll_ready,
    output logic       lock_lost,
    output logic [7:0] retry_cnt
);

    // One counter serves every state, so it is sized for the longest window.
    localparam int MAX_AB = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
                            RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                            MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          lock_m;
    logic          lock_s;
    logic          timeout;
    logic          drop;

    logic          pll_rst_d;
    logic          sys_rst_n_d;
    logic          pll_ready_d;
    logic          lock_lost_d;
    logic [7:0]    retry_d;

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // State and shared counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_PLL;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; a software request overrides every other exit,
    // but cannot shorten or restart an ongoing PLL reset hold.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        timeout = 1'b0;
        drop    = 1'b0;
        unique case (state)
            RESET_PLL: begin
                if (cnt == HOLD_LAST) begin
                    state_n = WAIT_LOCK;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (soft_rst_req) begin
                    state_n = RESET_PLL;
                end else if (lock_s) begin
                    state_n = STABLE;
                end else if (cnt == TMO_LAST) begin
                    state_n = RESET_PLL;
                    timeout = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STABLE: begin
                if (soft_rst_req) begin
                    state_n = RESET_PLL;
                end else if (!lock_s) begin
                    state_n = WAIT_LOCK;
                end else if (cnt == STAB_LAST) begin
                    state_n = RUN;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RUN: begin
                if (soft_rst_req) begin
                    state_n = RESET_PLL;
                end else if (!lock_s) begin
                    state_n = RESET_PLL;
                    drop    = 1'b1;
                end
            end
            default: begin
                state_n = RESET_PLL;
            end
        endcase
        if (state_n != state) begin
            cnt_n = '0;
        end
    end

    // Output values derived from the upcoming state so they change on the
    // same edge as the state itself.
    always_comb begin
        pll_rst_d   = (state_n == RESET_PLL);
        sys_rst_n_d = (state_n == RUN);
        pll_ready_d = (state_n == RUN);
        lock_lost_d = drop;
        retry_d     = retry_cnt;
        if (timeout && (retry_cnt != 8'hFF)) begin
            retry_d = retry_cnt + 8'd1;
        end
    end

    // Output registers; nothing reaches a port combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            pll_ready <= 1'b0;
            lock_lost <= 1'b0;
            retry_cnt <= 8'd0;
        end else begin
            pll_rst   <= pll_rst_d;
            sys_rst_n <= sys_rst_n_d;
            pll_ready <= pll_ready_d;
            lock_lost <= lock_lost_d;
            retry_cnt <= retry_d;
        end
    end

endmodule
